// File: rtl/stream_burst_pkg.sv
// Shared types and sizing helpers for the stream burst reader.
// Used by stream_burst_reader and stream_out_reg.
package stream_burst_pkg;

  // Reader states: waiting for a start condition, moving beats, draining the final beat.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BURST     = 2'd1,
    BURST_END = 2'd2
  } state_t;

  localparam int BURST_LEN_DEFAULT = 16;
  localparam int TIMEOUT_DEFAULT   = 1024;

  // Bits needed to hold values 0..max_value (at least one bit).
  function automatic int width_for(input int max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

  // Widths for the default configuration; the top recomputes them from its own parameters.
  localparam int REM_W   = width_for(BURST_LEN_DEFAULT);
  localparam int TIMER_W = width_for(TIMEOUT_DEFAULT);

endpackage

// File: rtl/stream_out_reg.sv
// One-entry AXI-Stream output register (data, valid, last).
// can_load tells the producer a new beat may be written this cycle: the slot is
// empty or its current beat is being accepted, so a load replaces it without loss.
module stream_out_reg #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             ready,
  output logic             can_load,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             last
);

  assign can_load = !valid || ready;

  // Hold the beat until accepted; a load in the acceptance cycle overwrites it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
      last  <= load_last;
    end else if (valid && ready) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_burst_reader.sv
// Burst reader: drains an upstream FIFO stream in bursts of up to BURST_LEN beats.
// A burst starts when BURST_LEN words are buffered, on flush, or after an idle
// timeout with a partial fill. The last beat of each burst carries TLAST.
// Optional macro STREAM_BURST_READER_STATS_EN adds burst_cnt / partial_cnt outputs.
//
// Handshake: a beat moves on a channel in any cycle where TVALID && TREADY are both
// high at the rising edge. The output side holds TDATA/TLAST stable while TVALID is
// high and TREADY is low, and TVALID never depends combinationally on TREADY.
module stream_burst_reader
  import stream_burst_pkg::*;
#(
  parameter int WIDTH     = 256,
  parameter int COUNT_W   = 14,
  parameter int BURST_LEN = BURST_LEN_DEFAULT,
  parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic [COUNT_W-1:0] fifo_count,
  input  logic               flush,
  input  logic [WIDTH-1:0]   in0_V_V_TDATA,
  input  logic               in0_V_V_TVALID,
  output logic               in0_V_V_TREADY,
  output logic [WIDTH-1:0]   out_V_V_TDATA,
  output logic               out_V_V_TVALID,
  input  logic               out_V_V_TREADY,
  output logic               out_V_V_TLAST,
`ifdef STREAM_BURST_READER_STATS_EN
  output logic [31:0]        burst_cnt,
  output logic [31:0]        partial_cnt,
`endif
  output state_t             dbg_state
);

  localparam int REM_BITS   = width_for(BURST_LEN);
  localparam int TIMER_BITS = width_for(TIMEOUT);

  localparam logic [COUNT_W-1:0]    BURST_LEN_CNT = COUNT_W'(BURST_LEN);
  localparam logic [REM_BITS-1:0]   BURST_LEN_REM = REM_BITS'(BURST_LEN);
  localparam logic [REM_BITS-1:0]   REM_ONE       = REM_BITS'(1);
  localparam logic [TIMER_BITS-1:0] TIMEOUT_VAL   = TIMER_BITS'(TIMEOUT);
  localparam logic [TIMER_BITS-1:0] TIMER_ONE     = TIMER_BITS'(1);
  localparam bit                    TIMEOUT_EN    = (TIMEOUT != 0);

  state_t                state_q, state_d;
  logic [TIMER_BITS-1:0] timer_q, timer_d;
  logic [REM_BITS-1:0]   remaining_q, remaining_d;

  logic count_full;
  logic count_zero;
  logic timer_hit;
  logic in_ready;
  logic load;
  logic load_last;
  logic can_load;
  logic burst_start;

  assign count_full = (fifo_count >= BURST_LEN_CNT);
  assign count_zero = (fifo_count == '0);
  assign timer_hit  = TIMEOUT_EN && (timer_q == TIMEOUT_VAL);

  assign in0_V_V_TREADY = in_ready;
  assign dbg_state      = state_q;

  // State, idle timer and beats-left counter.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      remaining_q <= remaining_d;
    end
  end

  // Next-state logic: burst start decision, beat transfer and end-of-burst drain.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    remaining_d = remaining_q;
    in_ready    = 1'b0;
    load        = 1'b0;
    load_last   = 1'b0;
    burst_start = 1'b0;
    case (state_q)
      IDLE: begin
        // The count cannot fall while idle (sole reader), so latching it is safe.
        if (count_full || (flush && !count_zero) || (timer_hit && !count_zero)) begin
          state_d     = BURST;
          timer_d     = '0;
          remaining_d = count_full ? BURST_LEN_REM : REM_BITS'(fifo_count);
          burst_start = 1'b1;
        end else if (count_zero) begin
          timer_d = '0;
        end else if (timer_q != TIMEOUT_VAL) begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      BURST: begin
        // Wait indefinitely for input; a burst is never aborted.
        in_ready = (remaining_q != '0) && can_load;
        if (in0_V_V_TVALID && in_ready) begin
          load        = 1'b1;
          remaining_d = remaining_q - REM_ONE;
          if (remaining_q == REM_ONE) begin
            load_last = 1'b1;
            state_d   = BURST_END;
          end
        end
      end
      BURST_END: begin
        if (out_V_V_TVALID && out_V_V_TREADY) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  stream_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .load      (load),
    .load_data (in0_V_V_TDATA),
    .load_last (load_last),
    .ready     (out_V_V_TREADY),
    .can_load  (can_load),
    .data      (out_V_V_TDATA),
    .valid     (out_V_V_TVALID),
    .last      (out_V_V_TLAST)
  );

`ifdef STREAM_BURST_READER_STATS_EN
  logic [REM_BITS-1:0] burst_len_q;
  logic                last_accept;

  assign last_accept = out_V_V_TVALID && out_V_V_TREADY && out_V_V_TLAST;

  // Remember the length of the current burst to classify it at its TLAST handshake.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      burst_len_q <= '0;
    end else if (burst_start) begin
      burst_len_q <= remaining_d;
    end
  end

  // Completed-burst and short-burst counters, wrapping modulo 2**32.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      burst_cnt   <= '0;
      partial_cnt <= '0;
    end else if (last_accept) begin
      burst_cnt <= burst_cnt + 32'd1;
      if (burst_len_q != BURST_LEN_REM) begin
        partial_cnt <= partial_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_stream_burst_reader.sv
// Testbench for stream_burst_reader: FIFO model upstream, scoreboard downstream.
module tb_stream_burst_reader;
  import stream_burst_pkg::*;

  localparam int WIDTH     = 256;
  localparam int COUNT_W   = 14;
  localparam int BURST_LEN = 16;
  localparam int TIMEOUT   = 1024;

  // ---------------- clock / reset ----------------
  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic [COUNT_W-1:0] fifo_count;
  logic               flush;
  logic [WIDTH-1:0]   in0_data;
  logic               in0_valid;
  logic               in0_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  state_t             dbg_state;
`ifdef STREAM_BURST_READER_STATS_EN
  logic [31:0]        burst_cnt;
  logic [31:0]        partial_cnt;
`endif

  stream_burst_reader #(
    .WIDTH     (WIDTH),
    .COUNT_W   (COUNT_W),
    .BURST_LEN (BURST_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .ap_clk         (ap_clk),
    .ap_rst_n       (ap_rst_n),
    .fifo_count     (fifo_count),
    .flush          (flush),
    .in0_V_V_TDATA  (in0_data),
    .in0_V_V_TVALID (in0_valid),
    .in0_V_V_TREADY (in0_ready),
    .out_V_V_TDATA  (out_data),
    .out_V_V_TVALID (out_valid),
    .out_V_V_TREADY (out_ready),
    .out_V_V_TLAST  (out_last),
`ifdef STREAM_BURST_READER_STATS_EN
    .burst_cnt      (burst_cnt),
    .partial_cnt    (partial_cnt),
`endif
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic             exp_last_q[$];
  logic [WIDTH-1:0] got_data_q[$];
  logic             got_last_q[$];
  int               got_cyc_q[$];
  int               cyc = 0;
  bit               pop_pending = 0;
  int               errors = 0;
  int               checks = 0;

  task automatic refresh_fifo();
    fifo_count = COUNT_W'(fifo_q.size());
    in0_valid  = (fifo_q.size() != 0);
    in0_data   = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  // Capture output handshakes and input pops at each rising edge.
  always @(posedge ap_clk) begin
    cyc = cyc + 1;
    if (out_valid && out_ready) begin
      got_data_q.push_back(out_data);
      got_last_q.push_back(out_last);
      got_cyc_q.push_back(cyc);
    end
    if (in0_valid && in0_ready) pop_pending = 1'b1;
  end

  // Upstream FIFO model: apply the pop and present the new head.
  always @(negedge ap_clk) begin
    if (pop_pending) begin
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      pop_pending = 1'b0;
    end
    refresh_fifo();
  end

  // ---------------- driver tasks ----------------
  task automatic add_words(input int n);
    logic [WIDTH-1:0] w;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < WIDTH / 32; j++) w[j*32 +: 32] = $urandom();
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
    refresh_fifo();
  endtask

  task automatic wait_got(input int n, input int budget, output bit ok);
    int cnt;
    cnt = 0;
    while (got_data_q.size() < n && cnt < budget) begin
      @(negedge ap_clk);
      cnt++;
    end
    ok = (got_data_q.size() >= n);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    exp_last_q.delete();
    got_data_q.delete();
    got_last_q.delete();
    got_cyc_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    flush = 1'b0;
    out_ready = 1'b0;
    refresh_fifo();
    repeat (3) @(negedge ap_clk);
    #1 ap_rst_n = 1'b1;
    @(negedge ap_clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", out_last); end
    checks++; if (in0_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in0_ready); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", out_data); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected IDLE", dbg_state); end
`ifdef STREAM_BURST_READER_STATS_EN
    checks++; if (burst_cnt !== 32'd0 || partial_cnt !== 32'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", burst_cnt, partial_cnt); end
`endif
  endtask

  task automatic test_full_burst();
    bit ok;
    int n, prev;
    logic [WIDTH-1:0] d, e;
    logic dl, el;
    @(negedge ap_clk); #1;
    clear_sb();
    out_ready = 1'b1;
    add_words(16);
    for (int i = 0; i < 16; i++) exp_last_q.push_back(i == 15);
    wait_got(16, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_count: got %0d beats expected 16", got_data_q.size()); end
    n = got_data_q.size();
    prev = 0;
    for (int i = 0; i < n; i++) begin
      d = got_data_q.pop_front(); e = exp_q.pop_front();
      dl = got_last_q.pop_front(); el = exp_last_q.pop_front();
      checks++; if (d !== e) begin errors++; $display("FAIL full_data[%0d]: got %h expected %h", i, d, e); end
      checks++; if (dl !== el) begin errors++; $display("FAIL full_last[%0d]: got %b expected %b", i, dl, el); end
      if (i > 0) begin
        checks++; if (got_cyc_q[i] != prev + 1) begin errors++; $display("FAIL full_gap[%0d]: got cycle %0d expected %0d", i, got_cyc_q[i], prev + 1); end
      end
      prev = got_cyc_q[i];
    end
    repeat (3) @(negedge ap_clk);
    checks++; if (in0_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready_after: got %b expected 0", in0_ready); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL full_state_after: got %0d expected IDLE", dbg_state); end
    checks++; if (fifo_q.size() != 0) begin errors++; $display("FAIL full_fifo_left: got %0d expected 0", fifo_q.size()); end
`ifdef STREAM_BURST_READER_STATS_EN
    checks++; if (burst_cnt !== 32'd1 || partial_cnt !== 32'd0) begin errors++; $display("FAIL full_stats: got %0d/%0d expected 1/0", burst_cnt, partial_cnt); end
`endif
  endtask

  task automatic test_timeout();
    bit ok;
    int n, c0;
    logic [WIDTH-1:0] d, e;
    logic dl, el;
    @(negedge ap_clk); #1;
    clear_sb();
    out_ready = 1'b1;
    c0 = cyc;
    add_words(5);
    for (int i = 0; i < 5; i++) exp_last_q.push_back(i == 4);
    wait_got(5, 1200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL timeout_count: got %0d beats expected 5", got_data_q.size()); end
    if (got_cyc_q.size() != 0) begin
      checks++; if (got_cyc_q[0] != c0 + TIMEOUT + 3) begin errors++; $display("FAIL timeout_start: got cycle %0d expected %0d", got_cyc_q[0], c0 + TIMEOUT + 3); end
    end
    n = got_data_q.size();
    for (int i = 0; i < n; i++) begin
      d = got_data_q.pop_front(); e = exp_q.pop_front();
      dl = got_last_q.pop_front(); el = exp_last_q.pop_front();
      checks++; if (d !== e) begin errors++; $display("FAIL timeout_data[%0d]: got %h expected %h", i, d, e); end
      checks++; if (dl !== el) begin errors++; $display("FAIL timeout_last[%0d]: got %b expected %b", i, dl, el); end
    end
    repeat (3) @(negedge ap_clk);
`ifdef STREAM_BURST_READER_STATS_EN
    checks++; if (burst_cnt !== 32'd2 || partial_cnt !== 32'd1) begin errors++; $display("FAIL timeout_stats: got %0d/%0d expected 2/1", burst_cnt, partial_cnt); end
`endif
  endtask

  task automatic test_flush();
    bit ok;
    int n, c0;
    logic [WIDTH-1:0] d, e;
    logic dl, el;
    @(negedge ap_clk); #1;
    clear_sb();
    out_ready = 1'b1;
    c0 = cyc;
    add_words(3);
    for (int i = 0; i < 3; i++) exp_last_q.push_back(i == 2);
    flush = 1'b1;
    @(negedge ap_clk); #1;
    flush = 1'b0;
    wait_got(3, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL flush_count: got %0d beats expected 3", got_data_q.size()); end
    if (got_cyc_q.size() != 0) begin
      checks++; if (got_cyc_q[0] != c0 + 3) begin errors++; $display("FAIL flush_start: got cycle %0d expected %0d", got_cyc_q[0], c0 + 3); end
    end
    n = got_data_q.size();
    for (int i = 0; i < n; i++) begin
      d = got_data_q.pop_front(); e = exp_q.pop_front();
      dl = got_last_q.pop_front(); el = exp_last_q.pop_front();
      checks++; if (d !== e) begin errors++; $display("FAIL flush_data[%0d]: got %h expected %h", i, d, e); end
      checks++; if (dl !== el) begin errors++; $display("FAIL flush_last[%0d]: got %b expected %b", i, dl, el); end
    end
    repeat (5) @(negedge ap_clk);
`ifdef STREAM_BURST_READER_STATS_EN
    checks++; if (burst_cnt !== 32'd3 || partial_cnt !== 32'd2) begin errors++; $display("FAIL flush_stats: got %0d/%0d expected 3/2", burst_cnt, partial_cnt); end
`endif
    // Flush with an empty FIFO must not start anything.
    #1 flush = 1'b1;
    @(negedge ap_clk); #1;
    flush = 1'b0;
    repeat (30) @(negedge ap_clk);
    checks++; if (got_data_q.size() != 0) begin errors++; $display("FAIL flush_empty_out: got %0d beats expected 0", got_data_q.size()); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL flush_empty_state: got %0d expected IDLE", dbg_state); end
  endtask

  task automatic test_backpressure();
    int n, cnt;
    bit stalled;
    logic [WIDTH-1:0] held_data, d, e;
    logic held_last, dl, el;
    @(negedge ap_clk); #1;
    clear_sb();
    out_ready = 1'b0;
    add_words(16);
    for (int i = 0; i < 16; i++) exp_last_q.push_back(i == 15);
    stalled = 1'b0;
    held_data = '0;
    held_last = 1'b0;
    cnt = 0;
    while (got_data_q.size() < 16 && cnt < 200) begin
      @(negedge ap_clk);
      cnt++;
      if (stalled) begin
        checks++; if (out_valid !== 1'b1 || out_data !== held_data || out_last !== held_last) begin
          errors++; $display("FAIL bp_hold: got v=%b last=%b data=%h expected v=1 last=%b data=%h", out_valid, out_last, out_data, held_last, held_data);
        end
      end
      out_ready = ~out_ready;
      stalled = out_valid && !out_ready;
      held_data = out_data;
      held_last = out_last;
    end
    out_ready = 1'b1;
    checks++; if (got_data_q.size() != 16) begin errors++; $display("FAIL bp_count: got %0d beats expected 16", got_data_q.size()); end
    n = got_data_q.size();
    for (int i = 0; i < n; i++) begin
      d = got_data_q.pop_front(); e = exp_q.pop_front();
      dl = got_last_q.pop_front(); el = exp_last_q.pop_front();
      checks++; if (d !== e) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", i, d, e); end
      checks++; if (dl !== el) begin errors++; $display("FAIL bp_last[%0d]: got %b expected %b", i, dl, el); end
    end
    repeat (5) @(negedge ap_clk);
    checks++; if (got_data_q.size() != 0) begin errors++; $display("FAIL bp_extra: got %0d extra beats expected 0", got_data_q.size()); end
`ifdef STREAM_BURST_READER_STATS_EN
    checks++; if (burst_cnt !== 32'd4 || partial_cnt !== 32'd2) begin errors++; $display("FAIL bp_stats: got %0d/%0d expected 4/2", burst_cnt, partial_cnt); end
`endif
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int n, c0;
    logic [WIDTH-1:0] d, e;
    logic dl, el;
    @(negedge ap_clk); #1;
    clear_sb();
    out_ready = 1'b1;
    add_words(16);
    wait_got(7, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_pre_count: got %0d beats expected 7", got_data_q.size()); end
    #1 ap_rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_mid_last: got %b expected 0", out_last); end
    checks++; if (in0_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready: got %b expected 0", in0_ready); end
    n = got_data_q.size();
    for (int i = 0; i < n; i++) begin
      d = got_data_q.pop_front(); e = exp_q.pop_front();
      checks++; if (d !== e) begin errors++; $display("FAIL rst_pre_data[%0d]: got %h expected %h", i, d, e); end
    end
`ifdef STREAM_BURST_READER_STATS_EN
    checks++; if (burst_cnt !== 32'd0 || partial_cnt !== 32'd0) begin errors++; $display("FAIL rst_mid_stats: got %0d/%0d expected 0/0", burst_cnt, partial_cnt); end
`endif
    // The word held in the output register is dropped; what is left upstream forms the next burst.
    clear_sb();
    foreach (fifo_q[i]) begin
      exp_q.push_back(fifo_q[i]);
      exp_last_q.push_back(i == fifo_q.size() - 1);
    end
    checks++; if (fifo_q.size() != 8) begin errors++; $display("FAIL rst_fifo_left: got %0d expected 8", fifo_q.size()); end
    @(negedge ap_clk); #1;
    ap_rst_n = 1'b1;
    c0 = cyc;
    #1;
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_release_state: got %0d expected IDLE", dbg_state); end
    wait_got(exp_q.size(), 1200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_post_count: got %0d beats expected %0d", got_data_q.size(), exp_q.size()); end
    if (got_cyc_q.size() != 0) begin
      checks++; if (got_cyc_q[0] != c0 + TIMEOUT + 3) begin errors++; $display("FAIL rst_timer_clear: got cycle %0d expected %0d", got_cyc_q[0], c0 + TIMEOUT + 3); end
    end
    n = got_data_q.size();
    for (int i = 0; i < n; i++) begin
      d = got_data_q.pop_front(); e = exp_q.pop_front();
      dl = got_last_q.pop_front(); el = exp_last_q.pop_front();
      checks++; if (d !== e) begin errors++; $display("FAIL rst_post_data[%0d]: got %h expected %h", i, d, e); end
      checks++; if (dl !== el) begin errors++; $display("FAIL rst_post_last[%0d]: got %b expected %b", i, dl, el); end
    end
    repeat (3) @(negedge ap_clk);
`ifdef STREAM_BURST_READER_STATS_EN
    checks++; if (burst_cnt !== 32'd1 || partial_cnt !== 32'd1) begin errors++; $display("FAIL rst_post_stats: got %0d/%0d expected 1/1", burst_cnt, partial_cnt); end
`endif
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    logic [WIDTH-1:0] d, e;
    logic dl, el;
    @(negedge ap_clk); #1;
    clear_sb();
    out_ready = 1'b1;
    add_words(40);
    for (int i = 0; i < 40; i++) exp_last_q.push_back(i == 15 || i == 31 || i == 39);
    wait_got(40, 1300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_count: got %0d beats expected 40", got_data_q.size()); end
    if (got_cyc_q.size() == 40) begin
      checks++; if (got_cyc_q[16] - got_cyc_q[15] != 3) begin errors++; $display("FAIL b2b_gap1: got %0d cycles expected 3", got_cyc_q[16] - got_cyc_q[15]); end
      checks++; if (got_cyc_q[31] - got_cyc_q[16] != 15) begin errors++; $display("FAIL b2b_burst2_span: got %0d cycles expected 15", got_cyc_q[31] - got_cyc_q[16]); end
      checks++; if (got_cyc_q[32] - got_cyc_q[31] != TIMEOUT + 3) begin errors++; $display("FAIL b2b_gap2: got %0d cycles expected %0d", got_cyc_q[32] - got_cyc_q[31], TIMEOUT + 3); end
    end
    n = got_data_q.size();
    for (int i = 0; i < n; i++) begin
      d = got_data_q.pop_front(); e = exp_q.pop_front();
      dl = got_last_q.pop_front(); el = exp_last_q.pop_front();
      checks++; if (d !== e) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, d, e); end
      checks++; if (dl !== el) begin errors++; $display("FAIL b2b_last[%0d]: got %b expected %b", i, dl, el); end
    end
    repeat (3) @(negedge ap_clk);
`ifdef STREAM_BURST_READER_STATS_EN
    checks++; if (burst_cnt !== 32'd4 || partial_cnt !== 32'd2) begin errors++; $display("FAIL b2b_stats: got %0d/%0d expected 4/2", burst_cnt, partial_cnt); end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_full_burst();
    test_timeout();
    test_flush();
    test_backpressure();
    test_reset_mid_burst();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so a stuck DUT cannot hang the run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
